register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port integer register file for the RV core: N read ports, M write ports,
//  per-register busy scoreboard for in-flight producers. Sits between decode (reads, reserves)
//  and writeback (writes). x0 is optionally hard-wired to zero.
// PARAMETERS
//  DATA_WIDTH  32  bits per register
//  ADDR_WIDTH  5   register index width; depth = 2**ADDR_WIDTH
//  NUM_RD      2   read ports (1..4)
//  NUM_WR      2   write ports (1..2)
//  ZERO_REG    1   1: register 0 reads 0, ignores writes and reserves; 0: register 0 is ordinary
// PORTS
//  clock_i        in   1                    single clock, rising edge
//  reset_n_i      in   1                    async reset, active-low
//  wr_en_i        in   NUM_WR               write enable per write port
//  wr_addr_i      in   NUM_WR*ADDR_WIDTH    write index, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//  wr_data_i      in   NUM_WR*DATA_WIDTH    write data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//  rd_addr_i      in   NUM_RD*ADDR_WIDTH    read index per read port
//  rd_data_o      out  NUM_RD*DATA_WIDTH    read data per read port
//  rd_busy_o      out  NUM_RD               1: register at rd_addr has a pending producer
//  rsv_en_i       in   1                    reserve request: mark rsv_addr_i busy
//  rsv_addr_i     in   ADDR_WIDTH           register to reserve
//  busy_vec_o     out  2**ADDR_WIDTH        full scoreboard, bit r = register r busy
// BEHAVIOUR
//  - Reset (reset_n_i low, async): all registers -> 0, all busy bits -> 0; outputs reflect that
//    immediately (rd_data_o = 0, rd_busy_o = 0, busy_vec_o = 0). Release is sampled at clock_i.
//  - Write: on rising edge, each port with wr_en_i=1 stores wr_data_i into wr_addr_i.
//    Same address on both write ports in one cycle: highest port index wins.
//    ZERO_REG=1 and addr 0: write dropped.
//  - Read: combinational from rd_addr_i, zero latency. ZERO_REG=1 and addr 0: data 0, busy 0.
//    Registers not written hold value (no implicit refresh).
//  - Scoreboard per register r, next state on rising edge:
//      set   = rsv_en_i & rsv_addr_i==r
//      clear = any wr_en_i[k] & wr_addr_i[k]==r
//      busy_next = set ? 1 : (clear ? 0 : busy)   -- reserve beats write on same register
//    (new producer supersedes the retiring one). ZERO_REG=1: bit 0 constant 0.
//  - rd_busy_o[p] = busy_vec_o[rd_addr_i[p]] (registered state only; same-cycle reserve/write
//    affects it from the next cycle).
//  - Writes to a non-busy register are legal and update data; busy stays 0.
//  - Reset asserted mid-cycle with writes/reserves pending: all dropped, state cleared.
//  - Arithmetic: index compares at ADDR_WIDTH exactly; no truncation or extension of data.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: rd_data_o[p] returns wr_data_i of the highest-index write port
//    with wr_en_i=1 and wr_addr_i==rd_addr_i[p] in the same cycle (write-through forwarding);
//    otherwise stored value. Zero register still reads 0. rd_busy_o unaffected.
//  Not defined: rd_data_o is stored value only; a write is visible the cycle after its edge.
// TESTING
//  1 Reset: hold reset_n_i low, then release -> every read port returns 0, busy_vec_o = 0.
//  2 Write x5=0xDEADBEEF via port 0, next cycle read port 1 addr 5 -> 0xDEADBEEF;
//    write x0=0x1234 -> reading x0 returns 0 (ZERO_REG=1).
//  3 Same cycle: port0 x7=0x11, port1 x7=0x22 -> x7 reads 0x22 afterwards.
//  4 Reserve x3 -> busy_vec_o[3]=1 next cycle, rd_busy_o=1 when reading 3; write x3=0x55 ->
//    busy 0 next cycle; reserve x3 and write x3 same cycle -> busy stays 1, data = write value.
//  5 Bypass: write x9=0xCAFE while reading x9 same cycle -> 0xCAFE with REGFILE_BYPASS_EN,
//    old value (0) without it; 0xCAFE next cycle in both builds.
//  6 Async reset pulsed mid-clock after x4=0x99 and reserve x4 -> x4 reads 0, busy_vec_o = 0
//    before the next clock edge.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port integer register file with a per-register busy scoreboard for in-flight producers.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic [NUM_WR-1:0]              wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0]   wr_data_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data_o,
  output logic [NUM_RD-1:0]              rd_busy_o,
  input  logic                           rsv_en_i,
  input  logic [ADDR_WIDTH-1:0]          rsv_addr_i,
  output logic [2**ADDR_WIDTH-1:0]       busy_vec_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_next;

  logic [ADDR_WIDTH-1:0] wr_addr [NUM_WR];
  logic [DATA_WIDTH-1:0] wr_data [NUM_WR];
  logic [NUM_WR-1:0]     wr_take;

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wr_addr[k] = wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data[k] = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign wr_take[k] = wr_en_i[k] && !((ZERO_REG != 0) && (wr_addr[k] == '0));
  end

  // Later write ports are applied last, so the highest index wins on an address clash.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_take[k]) begin
          regs[wr_addr[k]] <= wr_data[k];
        end
      end
      busy_q <= busy_next;
    end
  end

  // A reserve is applied after the write clears: the new producer supersedes the retiring one.
  always_comb begin
    busy_next = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en_i[k]) begin
        busy_next[wr_addr[k]] = 1'b0;
      end
    end
    if (rsv_en_i) begin
      busy_next[rsv_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  assign busy_vec_o = busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    assign addr = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      data = regs[addr];
      busy = busy_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (reset_n_i) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en_i[k] && (wr_addr[k] == addr)) begin
            data = wr_data[k];
          end
        end
      end
`endif
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy_o[p]                          = busy;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp against an array-based reference model.
module tb_register_file_mp;

  logic        clock_i = 1'b0;
  logic        reset_n_i = 1'b1;
  logic [1:0]  wr_en_i = '0;
  logic [9:0]  wr_addr_i = '0;
  logic [63:0] wr_data_i = '0;
  logic [9:0]  rd_addr_i = '0;
  logic [63:0] rd_data_o;
  logic [1:0]  rd_busy_o;
  logic        rsv_en_i = 1'b0;
  logic [4:0]  rsv_addr_i = '0;
  logic [31:0] busy_vec_o;

  int n_pass = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  logic [31:0] mem [32];
  bit          busy [32];

  register_file_mp dut (
    .clock_i    (clock_i),
    .reset_n_i  (reset_n_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .rsv_en_i   (rsv_en_i),
    .rsv_addr_i (rsv_addr_i),
    .busy_vec_o (busy_vec_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'd0;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wr_en_i[k] && wr_addr_i[k*5 +: 5] == a) v = wr_data_i[k*32 +: 32];
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_busy_vec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mem[r] = '0;
      busy[r] = 1'b0;
    end
  endtask

  // Reference: register 0 never changes; a reserve outranks a same-cycle write on busy.
  task automatic model_update();
    bit set, clr;
    if (!reset_n_i) return;
    for (int r = 1; r < 32; r++) begin
      set = rsv_en_i && rsv_addr_i == r[4:0];
      clr = (wr_en_i[0] && wr_addr_i[4:0] == r[4:0]) || (wr_en_i[1] && wr_addr_i[9:5] == r[4:0]);
      if (set) busy[r] = 1'b1;
      else if (clr) busy[r] = 1'b0;
    end
    for (int k = 0; k < 2; k++)
      if (wr_en_i[k] && wr_addr_i[k*5 +: 5] != 5'd0) mem[wr_addr_i[k*5 +: 5]] = wr_data_i[k*32 +: 32];
  endtask

  always @(negedge clock_i) begin
    if (check_en && reset_n_i) begin
      for (int p = 0; p < 2; p++) begin
        check_output($sformatf("rd_data[%0d] a=%0d", p, rd_addr_i[p*5 +: 5]),
                     {32'd0, rd_data_o[p*32 +: 32]}, {32'd0, exp_read(rd_addr_i[p*5 +: 5])});
        check_output($sformatf("rd_busy[%0d] a=%0d", p, rd_addr_i[p*5 +: 5]),
                     {63'd0, rd_busy_o[p]},
                     {63'd0, (rd_addr_i[p*5 +: 5] != 5'd0) && busy[rd_addr_i[p*5 +: 5]]});
      end
      check_output("busy_vec", {32'd0, busy_vec_o}, {32'd0, exp_busy_vec()});
    end
  end

  task automatic apply_stimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1, input logic re,
                                input logic [4:0] ra_rsv, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en_i    = we;
    wr_addr_i  = {wa1, wa0};
    wr_data_i  = {wd1, wd0};
    rsv_en_i   = re;
    rsv_addr_i = ra_rsv;
    rd_addr_i  = {ra1, ra0};
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    apply_stimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1);
  endtask

  task automatic tick();
    @(posedge clock_i);
    model_update();
    #1;
  endtask

  initial begin
    model_reset();
    #1 reset_n_i = 1'b0;
    #12;
    check_output("reset rd_data", rd_data_o, 64'd0);
    check_output("reset busy_vec", {32'd0, busy_vec_o}, 64'd0);
    @(negedge clock_i) reset_n_i = 1'b1;
    @(posedge clock_i) #1;
    check_en = 1'b1;

    idle(5'd1, 5'd31); #2;
    check_output("post-reset rd_data", rd_data_o, 64'd0);
    tick();

    apply_stimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0); tick();
    idle(5'd0, 5'd5); #2;
    check_output("x5 via port1", {32'd0, rd_data_o[63:32]}, 64'hDEADBEEF);
    tick();
    apply_stimulus(2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0); tick();
    idle(5'd0, 5'd0); #2;
    check_output("x0 reads zero", {32'd0, rd_data_o[31:0]}, 64'd0);
    check_output("x0 never busy", {63'd0, busy_vec_o[0]}, 64'd0);
    tick();

    apply_stimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0); tick();
    idle(5'd7, 5'd0); #2;
    check_output("x7 port1 wins", {32'd0, rd_data_o[31:0]}, 64'h22);
    tick();

    apply_stimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0); tick();
    idle(5'd3, 5'd0); #2;
    check_output("x3 reserved vec", {63'd0, busy_vec_o[3]}, 64'd1);
    check_output("x3 reserved rd_busy", {63'd0, rd_busy_o[0]}, 64'd1);
    tick();
    apply_stimulus(2'b01, 5'd3, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd0); tick();
    idle(5'd3, 5'd0); #2;
    check_output("x3 cleared by write", {63'd0, rd_busy_o[0]}, 64'd0);
    tick();
    apply_stimulus(2'b10, 5'd0, 32'd0, 5'd3, 32'h66, 1'b1, 5'd3, 5'd3, 5'd0); tick();
    idle(5'd3, 5'd0); #2;
    check_output("x3 reserve beats write", {63'd0, busy_vec_o[3]}, 64'd1);
    check_output("x3 data after rsv+write", {32'd0, rd_data_o[31:0]}, 64'h66);
    tick();

    apply_stimulus(2'b01, 5'd9, 32'hCAFE, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0); #2;
`ifdef REGFILE_BYPASS_EN
    check_output("x9 same-cycle bypass", {32'd0, rd_data_o[31:0]}, 64'hCAFE);
`else
    check_output("x9 same-cycle no bypass", {32'd0, rd_data_o[31:0]}, 64'd0);
`endif
    tick();
    idle(5'd9, 5'd0); #2;
    check_output("x9 next cycle", {32'd0, rd_data_o[31:0]}, 64'hCAFE);
    tick();

    apply_stimulus(2'b01, 5'd4, 32'h99, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0); tick();
    idle(5'd4, 5'd0); #2;
    check_output("x4 before reset", {32'd0, rd_data_o[31:0]}, 64'h99);
    check_output("x4 busy before reset", {63'd0, busy_vec_o[4]}, 64'd1);
    apply_stimulus(2'b01, 5'd4, 32'h77, 5'd0, 32'd0, 1'b1, 5'd6, 5'd4, 5'd0);
    check_en = 1'b0;
    reset_n_i = 1'b0;
    model_reset();
    #1;
    check_output("x4 after async reset", {32'd0, rd_data_o[31:0]}, 64'd0);
    check_output("busy_vec after async reset", {32'd0, busy_vec_o}, 64'd0);
    idle(5'd4, 5'd0);
    tick();
    @(negedge clock_i) reset_n_i = 1'b1;
    @(posedge clock_i) #1;
    check_en = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic [4:0] mask;
      mask = (i % 3 == 0) ? 5'h1F : 5'h07;
      apply_stimulus(2'($urandom), 5'($urandom) & mask, $urandom, 5'($urandom) & mask, $urandom,
                     ($urandom_range(0, 2) == 0), 5'($urandom) & mask,
                     5'($urandom) & mask, 5'($urandom) & mask);
      tick();
    end
    idle(5'd0, 5'd0);
    tick();
    check_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
